alu_share_arb: RTL and testbench

Round-robin arbiter and two-stage issue pipeline that shares one 32-bit ALU among `NUM_REQ` requesters. Each requester offers an operation with a valid/ready handshake. The arbiter grants at most one request per cycle, registers the operands and drives the ALU. The ALU result comes back on a shared, tagged response bus. The block sits between the datapath's operation sources and the ALU, which is instantiated outside this block and connected through the `alu_*` ports.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_share_rr_pick.sv | 67 ++++++
 rtl/alu_share_arb.sv | 142 ++++++++++++++
 tb/tb_alu_share_arb.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, legality check and the issue-stage operation record.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package alu_pkg;

  // ALU control codes understood by the shared ALU
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // One issued operation as held in the issue stage
  typedef struct packed {
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  ctrl;
    logic        err;
  } alu_op_t;

  // True when the ALU defines a behaviour for this control code
  function automatic logic alu_ctrl_legal(input logic [3:0] ctrl);
    logic legal;
    unique case (ctrl)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: legal = 1'b1;
      default:                                    legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Control code actually presented to the ALU; illegal codes become a harmless ADD
  function automatic logic [3:0] alu_issue_ctrl(input logic [3:0] ctrl);
    return alu_ctrl_legal(ctrl) ? ctrl : ALU_ADD;
  endfunction

endpackage

// File: rtl/alu_share_rr_pick.sv
// Combinational requester pick: one-hot grant plus binary index from the valid vector.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; a requester with its valid bit low is never picked.
// ALU_SHARE_ARB_RR_EN defined: round-robin search starting at ptr; undefined: fixed priority, lowest index wins.
module alu_share_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] valid,
`ifdef ALU_SHARE_ARB_RR_EN
  input  logic [ID_W-1:0]    ptr,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

`ifdef ALU_SHARE_ARB_RR_EN
  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [ID_W-1:0]      off;
  logic [ID_W:0]        sum;

  // Rotate the valid vector so that bit 0 is the requester at the pointer
  assign dbl = {valid, valid} >> ptr;
  assign rot = dbl[NUM_REQ-1:0];

  // Distance from the pointer to the first valid requester (lowest set bit of rot)
  always_comb begin
    off = '0;
    any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = ID_W'(i);
        any = 1'b1;
      end
    end
  end

  // Undo the rotation: index = (ptr + off) mod NUM_REQ
  always_comb begin
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NUM_REQ_W) begin
      sum = sum - NUM_REQ_W;
    end
  end

  assign idx = sum[ID_W-1:0];
`else
  // Fixed priority: lowest valid index wins
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid[i]) begin
        idx = ID_W'(i);
        any = 1'b1;
      end
    end
  end
`endif

  assign grant = any ? (NUM_REQ'(1) << idx) : '0;

endmodule

// File: rtl/alu_share_arb.sv
// Shares one external 32-bit ALU among NUM_REQ requesters: arbitrate, register operands (S1), capture result (S2).
// Latency: grant in cycle N -> resp_valid_o in cycle N+2; one request accepted per cycle, back-to-back.
// Backpressure: requesters see a combinational grant on req_ready_o; the response bus has none. Macro: ALU_SHARE_ARB_RR_EN.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*32-1:0] req_src1_i,
  input  logic [NUM_REQ*32-1:0] req_src2_i,
  input  logic [NUM_REQ*4-1:0]  req_ctrl_i,
  output logic [31:0]           alu_src1_o,
  output logic [31:0]           alu_src2_o,
  output logic [3:0]            alu_ctrl_o,
  input  logic [31:0]           alu_result_i,
  input  logic                  alu_zero_i,
  output logic                  resp_valid_o,
  output logic [ID_W-1:0]       resp_id_o,
  output logic [31:0]           resp_result_o,
  output logic                  resp_zero_o,
  output logic                  resp_err_o,
  output logic                  busy_o
);

  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;

  alu_op_t            sel_op;
  alu_op_t            s1_op;
  logic               s1_valid;
  logic [ID_W-1:0]    s1_id;
  logic               s2_valid;

`ifdef ALU_SHARE_ARB_RR_EN
  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0] rr_ptr;
`endif

  alu_share_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .valid (req_valid_i),
`ifdef ALU_SHARE_ARB_RR_EN
    .ptr   (rr_ptr),
`endif
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign req_ready_o = pick_grant;

`ifdef ALU_SHARE_ARB_RR_EN
  // Pointer moves to the requester after the one just granted; holds when idle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (pick_any) begin
      rr_ptr <= (pick_idx == LAST_IDX) ? '0 : pick_idx + ID_W'(1);
    end
  end
`endif

  // Select the granted requester's operation (one-hot AND-OR mux) and classify its code
  always_comb begin
    sel_op = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_grant[k]) begin
        sel_op.src1 = req_src1_i[k*32 +: 32];
        sel_op.src2 = req_src2_i[k*32 +: 32];
        sel_op.ctrl = req_ctrl_i[k*4 +: 4];
      end
    end
    sel_op.err = ~alu_ctrl_legal(sel_op.ctrl);
  end

  // Issue stage: register the granted operation and its owner tag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_op    <= '0;
    end else begin
      s1_valid <= pick_any;
      if (pick_any) begin
        s1_id <= pick_idx;
        s1_op <= sel_op;
      end
    end
  end

  // Drive the ALU from S1; quiet AND of zeros when idle, ADD in place of an illegal code
  always_comb begin
    alu_src1_o = '0;
    alu_src2_o = '0;
    alu_ctrl_o = ALU_AND;
    if (s1_valid) begin
      alu_src1_o = s1_op.src1;
      alu_src2_o = s1_op.src2;
      alu_ctrl_o = alu_issue_ctrl(s1_op.ctrl);
    end
  end

  // Response stage: capture the ALU return, forcing result 0 / zero 1 for illegal codes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_valid      <= 1'b0;
      resp_id_o     <= '0;
      resp_result_o <= '0;
      resp_zero_o   <= 1'b0;
      resp_err_o    <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        resp_id_o     <= s1_id;
        resp_err_o    <= s1_op.err;
        resp_result_o <= s1_op.err ? 32'd0 : alu_result_i;
        resp_zero_o   <= s1_op.err ? 1'b1 : alu_zero_i;
      end
    end
  end

  // Busy flop tracks the next-state OR of both stage valids, so it equals s1_valid | s2_valid glitch-free
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_o <= 1'b0;
    end else begin
      busy_o <= pick_any | s1_valid;
    end
  end

  assign resp_valid_o = s2_valid;

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed scenarios plus random traffic against a reference model.
// Latency: responses expected two cycles after each modelled grant.
// Backpressure: requesters hold valid and operands until granted; every response is consumed.
module tb_alu_share_arb;

  localparam int NR = 2;
  localparam int IW = 2;

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        zero;
    logic        err;
    int          due;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR-1:0]     rv  = '0;
  logic [31:0]       ra [NR];
  logic [31:0]       rb [NR];
  logic [3:0]        rc [NR];

  logic [NR-1:0]     req_ready_o;
  logic [NR*32-1:0]  req_src1_i;
  logic [NR*32-1:0]  req_src2_i;
  logic [NR*4-1:0]   req_ctrl_i;
  logic [31:0]       alu_src1_o;
  logic [31:0]       alu_src2_o;
  logic [3:0]        alu_ctrl_o;
  logic [31:0]       alu_result_i;
  logic              alu_zero_i;
  logic              resp_valid_o;
  logic [IW-1:0]     resp_id_o;
  logic [31:0]       resp_result_o;
  logic              resp_zero_o;
  logic              resp_err_o;
  logic              busy_o;

  op_t   pend0[$];
  op_t   pend1[$];
  exp_t  sb[$];
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    gate  = 100;
  int    mptr  = 0;
  bit [NR-1:0] took = '0;
  bit    g1 = 1'b0;
  bit    g2 = 1'b0;
  op_t   op1;
  bit    flag_timeout = 1'b0;
  bit    req_drain    = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  alu_share_arb #(.NUM_REQ(NR), .ID_W(IW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (rv),
    .req_ready_o   (req_ready_o),
    .req_src1_i    (req_src1_i),
    .req_src2_i    (req_src2_i),
    .req_ctrl_i    (req_ctrl_i),
    .alu_src1_o    (alu_src1_o),
    .alu_src2_o    (alu_src2_o),
    .alu_ctrl_o    (alu_ctrl_o),
    .alu_result_i  (alu_result_i),
    .alu_zero_i    (alu_zero_i),
    .resp_valid_o  (resp_valid_o),
    .resp_id_o     (resp_id_o),
    .resp_result_o (resp_result_o),
    .resp_zero_o   (resp_zero_o),
    .resp_err_o    (resp_err_o),
    .busy_o        (busy_o)
  );

  function automatic bit ref_legal(input logic [3:0] c);
    return c inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111};
  endfunction

  function automatic logic [31:0] ref_res(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Packing of per-requester fields onto the flat buses
  always_comb begin
    req_src1_i = '0;
    req_src2_i = '0;
    req_ctrl_i = '0;
    for (int k = 0; k < NR; k++) begin
      req_src1_i[k*32 +: 32] = ra[k];
      req_src2_i[k*32 +: 32] = rb[k];
      req_ctrl_i[k*4 +: 4]   = rc[k];
    end
  end

  // External ALU: behaves well on legal codes, returns garbage on anything else
  always_comb begin
    alu_result_i = ref_legal(alu_ctrl_o) ? ref_res(alu_ctrl_o, alu_src1_o, alu_src2_o) : 32'hBAD0_BAD0;
    alu_zero_i   = (alu_result_i == 32'd0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  // Monitor/scoreboard: compares grants, ALU drive, busy and responses at the falling edge
  always @(negedge clk) begin
    logic [NR-1:0] expg;
    int            w;
    exp_t          e;
    if (flag_timeout) begin
      total++;
      bad++;
      $display("FAIL wait_grant cyc=%0d got=no_grant want=grant_to_req0", cyc);
      flag_timeout = 1'b0;
    end
    if (req_drain) begin
      chk("drain_empty", 64'(sb.size()), 64'd0);
      req_drain = 1'b0;
    end
    if (rst) begin
      chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_resp_id", 64'(resp_id_o), 64'd0);
      chk("rst_resp_result", 64'(resp_result_o), 64'd0);
      chk("rst_resp_zero", 64'(resp_zero_o), 64'd0);
      chk("rst_resp_err", 64'(resp_err_o), 64'd0);
      sb.delete();
      mptr = 0;
      g1   = 1'b0;
      g2   = 1'b0;
      took = '0;
    end else begin
      // ALU drive during the cycle after a grant
      if (g1) begin
        chk("alu_ctrl", 64'(alu_ctrl_o), ref_legal(op1.c) ? 64'(op1.c) : 64'd2);
        chk("alu_src1", 64'(alu_src1_o), 64'(op1.a));
        chk("alu_src2", 64'(alu_src2_o), 64'(op1.b));
      end else begin
        chk("alu_idle_ctrl", 64'(alu_ctrl_o), 64'd0);
        chk("alu_idle_src", {alu_src1_o, alu_src2_o}, 64'd0);
      end
      chk("busy", 64'(busy_o), 64'(g1 | g2));

      // Responses
      if (resp_valid_o) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL resp_spurious cyc=%0d got=id%0d want=no_response", cyc, resp_id_o);
        end else begin
          e = sb.pop_front();
          chk("resp_cycle", 64'(cyc), 64'(e.due));
          chk("resp_id", 64'(resp_id_o), 64'(e.id));
          chk("resp_result", 64'(resp_result_o), 64'(e.res));
          chk("resp_zero", 64'(resp_zero_o), 64'(e.zero));
          chk("resp_err", 64'(resp_err_o), 64'(e.err));
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        total++;
        bad++;
        $display("FAIL resp_missing cyc=%0d got=no_response want=id%0d", cyc, sb[0].id);
        void'(sb.pop_front());
      end

      // Arbitration model
      w = -1;
`ifdef ALU_SHARE_ARB_RR_EN
      for (int i = 0; i < NR; i++) begin
        if (w < 0 && rv[(mptr + i) % NR]) w = (mptr + i) % NR;
      end
`else
      for (int i = 0; i < NR; i++) begin
        if (w < 0 && rv[i]) w = i;
      end
`endif
      expg = (w >= 0) ? NR'(1) << w : '0;
      chk("grant", 64'(req_ready_o), 64'(expg));
      took = req_ready_o & rv;

      g2 = g1;
      g1 = (w >= 0);
      if (w >= 0) begin
        op1.c = rc[w];
        op1.a = ra[w];
        op1.b = rb[w];
        e.id   = w;
        e.err  = !ref_legal(rc[w]);
        e.res  = ref_res(rc[w], ra[w], rb[w]);
        e.zero = e.err ? 1'b1 : (e.res == 32'd0);
        e.due  = cyc + 2;
        sb.push_back(e);
`ifdef ALU_SHARE_ARB_RR_EN
        mptr = (w + 1) % NR;
`endif
      end
    end
  end

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  function automatic op_t rand_op();
    op_t o;
    case ($urandom_range(0, 7))
      0:       o.c = 4'b0000;
      1:       o.c = 4'b0001;
      2:       o.c = 4'b0010;
      3:       o.c = 4'b0110;
      4:       o.c = 4'b0111;
      default: o.c = 4'($urandom);
    endcase
    o.a = rand_word();
    o.b = ($urandom_range(0, 3) == 0) ? o.a : rand_word();
    return o;
  endfunction

  function automatic op_t mk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    op_t o;
    o.c = c;
    o.a = a;
    o.b = b;
    return o;
  endfunction

  // Requester k: drop a granted request, optionally present its next queued op
  task automatic advance(input int k);
    op_t o;
    bool_present: begin
      if (took[k] || !rv[k]) begin
        rv[k] = 1'b0;
        ra[k] = $urandom;
        rb[k] = $urandom;
        rc[k] = 4'($urandom);
        if ($urandom_range(0, 99) < gate) begin
          if (k == 0 && pend0.size() > 0) begin
            o = pend0.pop_front();
            rv[k] = 1'b1;
          end else if (k == 1 && pend1.size() > 0) begin
            o = pend1.pop_front();
            rv[k] = 1'b1;
          end
          if (rv[k]) begin
            ra[k] = o.a;
            rb[k] = o.b;
            rc[k] = o.c;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    advance(0);
    advance(1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int k = 0; k < NR; k++) begin
      ra[k] = '0;
      rb[k] = '0;
      rc[k] = '0;
    end
    #1 rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(2);

    // Single ADD 5+7 from requester 0
    pend0.push_back(mk(4'b0010, 32'd5, 32'd7));
    run(5);

    // Both requesters hold SUB 9-9
    for (int i = 0; i < 2; i++) begin
      pend0.push_back(mk(4'b0110, 32'd9, 32'd9));
      pend1.push_back(mk(4'b0110, 32'd9, 32'd9));
    end
    run(7);

    // Illegal control code
    pend0.push_back(mk(4'b1111, 32'd3, 32'd4));
    run(5);

    // Unsigned SLT
    pend1.push_back(mk(4'b0111, 32'd2, 32'd3));
    pend1.push_back(mk(4'b0111, 32'hFFFF_FFFF, 32'd1));
    run(6);

    // Reset one cycle after a grant; queued work from both requesters waits across reset
    pend0.push_back(mk(4'b0010, 32'd1, 32'd1));
    step();
    begin
      int i;
      for (i = 0; i < 10; i++) begin
        @(negedge clk);
        #1;
        if (took[0]) break;
        step();
      end
      if (i == 10) flag_timeout = 1'b1;
    end
    pend0.push_back(mk(4'b0001, 32'hF0, 32'h0F));
    pend1.push_back(mk(4'b0000, 32'hFF, 32'h3C));
    step();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(6);

    // Both valid for three requests each (starvation under fixed priority)
    for (int i = 0; i < 3; i++) begin
      pend0.push_back(mk(4'b0010, 32'(i), 32'd100));
      pend1.push_back(mk(4'b0001, 32'(i), 32'd200));
    end
    run(9);

    // Random traffic with random presentation gaps
    for (int n = 0; n < 1500; n++) begin
      gate = $urandom_range(40, 100);
      if (pend0.size() < 3 && $urandom_range(0, 1) == 1) pend0.push_back(rand_op());
      if (pend1.size() < 3 && $urandom_range(0, 1) == 1) pend1.push_back(rand_op());
      step();
    end

    // Drain, bounded
    gate = 100;
    for (int i = 0; i < 60 && (pend0.size() > 0 || pend1.size() > 0 || rv != '0 || sb.size() > 0); i++) begin
      step();
    end
    req_drain = 1'b1;
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
